// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter fed by a word FIFO, configurable data/parity/stop framing
// Frames leave back-to-back whenever the FIFO holds a word at the end of the last stop bit.
module uart_tx_fifo #(
   parameter int CLK_FREQ   = 36000000,
   parameter int UART_BPS   = 9600,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          tx_valid,
   input  logic [DATA_BITS-1:0]          tx_data,
   output logic                          tx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          uart_tx_busy,
   output logic                          tx_done,
   output logic                          uart_txd
);

   localparam int BPS_CNT = CLK_FREQ / UART_BPS;
   localparam int CW      = $clog2(BPS_CNT);
   localparam int AW      = $clog2(FIFO_DEPTH);

   localparam logic [CW-1:0] CLK_LAST  = CW'(BPS_CNT - 1);
   localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
   localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(FIFO_DEPTH);
   localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
   localparam logic          ODD_PAR   = (PARITY == 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [AW:0]          r_count;

   state_t               r_state;
   logic [CW-1:0]        r_clk_cnt;
   logic [3:0]           r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_parity;
   logic                 r_txd;
   logic                 r_busy;

   logic                 w_empty;
   logic                 w_full;
   logic                 w_push;
   logic                 w_pop;
   logic                 w_load;
   logic                 w_bit_end;
   logic                 w_done;
   logic [DATA_BITS-1:0] w_head;

   state_t               w_state_nxt;
   logic [CW-1:0]        w_clk_nxt;
   logic [3:0]           w_bit_nxt;
   logic [DATA_BITS-1:0] w_shift_nxt;
   logic                 w_par_nxt;
   logic                 w_txd_nxt;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_FULL);
   // A pop in this cycle frees a slot, so a full FIFO may still take a word.
   assign tx_ready  = !w_full || w_pop;
   assign w_push    = tx_valid && tx_ready;
   assign w_head    = r_mem[r_rd_ptr];
   assign w_bit_end = (r_clk_cnt == CLK_LAST);

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= tx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_ONE;
            2'b01:   r_count <= r_count - CNT_ONE;
            default: r_count <= r_count;
         endcase
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_clk_nxt   = r_clk_cnt;
      w_bit_nxt   = r_bit_cnt;
      w_shift_nxt = r_shift;
      w_par_nxt   = r_parity;
      w_txd_nxt   = r_txd;
      w_load      = 1'b0;
      w_pop       = 1'b0;
      w_done      = 1'b0;

      if (r_state != S_IDLE) begin
         w_clk_nxt = w_bit_end ? '0 : r_clk_cnt + 1'b1;
      end

      case (r_state)
         S_IDLE: begin
            w_clk_nxt = '0;
            w_txd_nxt = 1'b1;
            w_load    = !w_empty;
         end
         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_bit_nxt   = '0;
               w_txd_nxt   = r_shift[0];
            end
         end
         S_DATA: begin
            if (w_bit_end) begin
               if (r_bit_cnt == DATA_LAST) begin
                  w_bit_nxt = '0;
                  if (PARITY != 0) begin
                     w_state_nxt = S_PARITY;
                     w_txd_nxt   = r_parity;
                  end else begin
                     w_state_nxt = S_STOP;
                     w_txd_nxt   = 1'b1;
                  end
               end else begin
                  w_bit_nxt   = r_bit_cnt + 4'd1;
                  w_shift_nxt = r_shift >> 1;
                  w_txd_nxt   = r_shift[1];
               end
            end
         end
         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = S_STOP;
               w_bit_nxt   = '0;
               w_txd_nxt   = 1'b1;
            end
         end
         S_STOP: begin
            if (w_bit_end) begin
               if (r_bit_cnt == STOP_LAST) begin
                  w_done = 1'b1;
                  if (w_empty) begin
                     w_state_nxt = S_IDLE;
                  end else begin
                     w_load = 1'b1;
                  end
               end else begin
                  w_bit_nxt = r_bit_cnt + 4'd1;
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_txd_nxt   = 1'b1;
         end
      endcase

      // Popping drives the start bit on the same edge, from IDLE or straight out of STOP.
      if (w_load) begin
         w_pop       = 1'b1;
         w_state_nxt = S_START;
         w_bit_nxt   = '0;
         w_shift_nxt = w_head;
         w_par_nxt   = (^w_head) ^ ODD_PAR;
         w_txd_nxt   = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_clk_cnt <= '0;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
         r_txd     <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_clk_cnt <= w_clk_nxt;
         r_bit_cnt <= w_bit_nxt;
         r_shift   <= w_shift_nxt;
         r_parity  <= w_par_nxt;
         r_txd     <= w_txd_nxt;
         r_busy    <= (w_state_nxt != S_IDLE);
      end
   end

   assign uart_txd     = r_txd;
   assign uart_tx_busy = r_busy;
   assign tx_done      = w_done;
   assign fifo_count   = r_count;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - directed bench for uart_tx_fifo over 8N1, 8E1, 8O1, 7N2 and 9N1 framings
module tb_uart_tx_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [4:0] valid;
   logic [8:0] data [5];
   logic [4:0] ready;
   logic [4:0] busy;
   logic [4:0] done;
   logic [4:0] txd;
   logic [4:0] cnt [5];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   uart_tx_fifo #(.CLK_FREQ(160), .UART_BPS(10), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8n1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid[0]), .tx_data(data[0][7:0]), .tx_ready(ready[0]),
      .fifo_count(cnt[0]), .uart_tx_busy(busy[0]), .tx_done(done[0]), .uart_txd(txd[0]));

   uart_tx_fifo #(.CLK_FREQ(160), .UART_BPS(10), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8e1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid[1]), .tx_data(data[1][7:0]), .tx_ready(ready[1]),
      .fifo_count(cnt[1]), .uart_tx_busy(busy[1]), .tx_done(done[1]), .uart_txd(txd[1]));

   uart_tx_fifo #(.CLK_FREQ(160), .UART_BPS(10), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_8o1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid[2]), .tx_data(data[2][7:0]), .tx_ready(ready[2]),
      .fifo_count(cnt[2]), .uart_tx_busy(busy[2]), .tx_done(done[2]), .uart_txd(txd[2]));

   uart_tx_fifo #(.CLK_FREQ(160), .UART_BPS(10), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)) u_7n2 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid[3]), .tx_data(data[3][6:0]), .tx_ready(ready[3]),
      .fifo_count(cnt[3]), .uart_tx_busy(busy[3]), .tx_done(done[3]), .uart_txd(txd[3]));

   uart_tx_fifo #(.CLK_FREQ(160), .UART_BPS(10), .DATA_BITS(9), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_9n1 (
      .clk(clk), .rst_n(rst_n), .tx_valid(valid[4]), .tx_data(data[4][8:0]), .tx_ready(ready[4]),
      .fifo_count(cnt[4]), .uart_tx_busy(busy[4]), .tx_done(done[4]), .uart_txd(txd[4]));

   task automatic test_reset();
      checks++;
      if (txd !== 5'b11111 || busy !== 5'b00000 || done !== 5'b00000 || ready !== 5'b11111) begin
         errors++;
         $display("FAIL reset_outputs: txd=%b busy=%b done=%b ready=%b, required 11111 00000 00000 11111",
                  txd, busy, done, ready);
      end
      checks++;
      if (cnt[0] !== 5'd0) begin
         errors++;
         $display("FAIL reset_count: fifo_count=%0d, required 0", cnt[0]);
      end
   endtask

   // One word into an idle block; frame bits sampled mid-bit, exp[b] is frame bit b.
   task automatic run_frame(input int idx, input logic [8:0] d, input logic [15:0] exp,
                            input int nbits, input string nm);
      int len;
      len = nbits * 16;
      @(negedge clk);
      valid[idx] = 1'b1;
      data[idx]  = d;
      @(negedge clk);
      valid[idx] = 1'b0;
      checks++;
      if (txd[idx] !== 1'b1 || cnt[idx] !== 5'd1) begin
         errors++;
         $display("FAIL %s write_edge: txd=%b count=%0d, required txd=1 count=1", nm, txd[idx], cnt[idx]);
      end
      @(negedge clk);
      checks++;
      if (txd[idx] !== 1'b0 || busy[idx] !== 1'b1 || cnt[idx] !== 5'd0) begin
         errors++;
         $display("FAIL %s start_edge: txd=%b busy=%b count=%0d, required 0 1 0", nm, txd[idx], busy[idx], cnt[idx]);
      end
      for (int c = 0; c < len; c++) begin
         if (c > 0) @(negedge clk);
         if (c % 16 == 8) begin
            checks++;
            if (txd[idx] !== exp[c/16]) begin
               errors++;
               $display("FAIL %s bit%0d: txd=%b, required %b", nm, c/16, txd[idx], exp[c/16]);
            end
         end
         if (c == len - 1) begin
            checks++;
            if (done[idx] !== 1'b1) begin
               errors++;
               $display("FAIL %s tx_done_last: tx_done=%b at clock %0d, required 1", nm, done[idx], c);
            end
         end else if (done[idx] !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL %s tx_done_early: tx_done=%b at clock %0d, required 0", nm, done[idx], c);
         end
      end
      @(negedge clk);
      checks++;
      if (txd[idx] !== 1'b1 || busy[idx] !== 1'b0 || done[idx] !== 1'b0) begin
         errors++;
         $display("FAIL %s after_frame: txd=%b busy=%b done=%b, required 1 0 0", nm, txd[idx], busy[idx], done[idx]);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] words [19];
      logic [9:0] fr;
      int cyc, f, c;
      logic pushed;
      for (int i = 0; i < 17; i++) words[i] = 8'(i * 29 + 3);
      words[17] = 8'hE0;
      words[18] = 8'hE1;
      pushed = 1'b0;
      @(negedge clk);
      valid[0] = 1'b1;
      data[0]  = {1'b0, words[0]};
      for (int t = 1; t <= 2 + 19 * 160 + 1; t++) begin
         @(negedge clk);
         cyc = t - 2;
         if (t < 17) begin
            data[0] = {1'b0, words[t]};
         end else if (t == 17) begin
            data[0] = 9'h05A;
         end else if (t == 18) begin
            valid[0] = 1'b0;
            checks++;
            if (cnt[0] !== 5'd16 || ready[0] !== 1'b0) begin
               errors++;
               $display("FAIL b2b_fill: count=%0d ready=%b, required 16 0", cnt[0], ready[0]);
            end
         end
         if (pushed) begin
            pushed   = 1'b0;
            valid[0] = 1'b0;
            checks++;
            if (cnt[0] !== 5'd16) begin
               errors++;
               $display("FAIL b2b_push_pop: count=%0d, required 16", cnt[0]);
            end
         end
         if (cyc >= 0 && cyc < 19 * 160) begin
            f  = cyc / 160;
            c  = cyc % 160;
            fr = {1'b1, words[f], 1'b0};
            if (c % 16 == 8) begin
               checks++;
               if (txd[0] !== fr[c/16] || busy[0] !== 1'b1) begin
                  errors++;
                  $display("FAIL b2b_frame%0d_bit%0d: txd=%b busy=%b, required %b 1", f, c/16, txd[0], busy[0], fr[c/16]);
               end
            end
            if (c == 159) begin
               checks++;
               if (done[0] !== 1'b1) begin
                  errors++;
                  $display("FAIL b2b_done%0d: tx_done=%b, required 1", f, done[0]);
               end
               if (f < 2) begin
                  checks++;
                  if (ready[0] !== 1'b1 || cnt[0] !== 5'd16) begin
                     errors++;
                     $display("FAIL b2b_full_pop_ready: ready=%b count=%0d, required 1 16", ready[0], cnt[0]);
                  end
                  valid[0] = 1'b1;
                  data[0]  = {1'b0, words[17 + f]};
                  pushed   = 1'b1;
               end
            end else if (done[0] !== 1'b0) begin
               checks++;
               errors++;
               $display("FAIL b2b_done_stray: tx_done=%b frame %0d clock %0d, required 0", done[0], f, c);
            end
         end
         if (cyc == 19 * 160) begin
            checks++;
            if (txd[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 5'd0) begin
               errors++;
               $display("FAIL b2b_drained: txd=%b busy=%b count=%0d, required 1 0 0", txd[0], busy[0], cnt[0]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_frame();
      logic bad;
      @(negedge clk);
      valid[0] = 1'b1;
      data[0]  = 9'h000;
      repeat (4) @(negedge clk);
      valid[0] = 1'b0;
      checks++;
      if (cnt[0] !== 5'd3) begin
         errors++;
         $display("FAIL rst_queued: count=%0d, required 3", cnt[0]);
      end
      repeat (68) @(negedge clk);
      checks++;
      if (txd[0] !== 1'b0 || busy[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_bit4: txd=%b busy=%b, required 0 1", txd[0], busy[0]);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (txd[0] !== 1'b1 || cnt[0] !== 5'd0 || busy[0] !== 1'b0 || ready[0] !== 1'b1) begin
         errors++;
         $display("FAIL rst_async: txd=%b count=%0d busy=%b ready=%b, required 1 0 0 1",
                  txd[0], cnt[0], busy[0], ready[0]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 1'b0;
      repeat (400) begin
         @(negedge clk);
         if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad = 1'b1;
      end
      checks++;
      if (bad !== 1'b0) begin
         errors++;
         $display("FAIL rst_no_resume: activity seen after reset release, required txd=1 busy=0 throughout");
      end
   endtask

   task automatic test_9n1();
      run_frame(4, 9'h1FF, 16'({1'b1, 9'h1FF, 1'b0}), 11, "9n1");
      repeat (20) @(negedge clk);
      checks++;
      if (txd[4] !== 1'b1 || busy[4] !== 1'b0 || cnt[4] !== 5'd0) begin
         errors++;
         $display("FAIL 9n1_idle: txd=%b busy=%b count=%0d, required 1 0 0", txd[4], busy[4], cnt[4]);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      valid = 5'b00000;
      for (int i = 0; i < 5; i++) data[i] = 9'h000;
      #12;
      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      run_frame(0, 9'h0A5, 16'({1'b1, 8'hA5, 1'b0}), 10, "8n1_a5");
      run_frame(1, 9'h007, 16'({1'b1, 1'b1, 8'h07, 1'b0}), 11, "8e1_07");
      run_frame(2, 9'h007, 16'({1'b1, 1'b0, 8'h07, 1'b0}), 11, "8o1_07");
      run_frame(3, 9'h055, 16'({2'b11, 7'h55, 1'b0}), 10, "7n2_55");
      test_back_to_back();
      test_reset_mid_frame();
      test_9n1();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
